uart_rx_fifo: RTL and testbench

//  - Serial receive front end of the CPU: turns the 8N1 byte stream arriving on Rx (from the UART

---
 rtl/uart_rx_fifo.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Serial receive front end. A 2-flop synchronizer feeds an oversampling
//   receiver FSM (IDLE -> START -> DATA -> STOP). Each good byte is written
//   into a first-word-fall-through FIFO, and the FIFO head is presented on a
//   valid/ready port.
//
//   Optional build macro: UART_RX_PARITY_EN
//     undefined : 8N1 frames
//     defined   : 8E1 frames; a PARITY state is added and the parity_err
//                 output is present
//
// Ports
//   CLK          in   system clock, rising edge
//   RST          in   asynchronous reset, active low
//   Rx           in   serial line, idle high, asynchronous to CLK
//   out_data     out  FIFO head byte, valid while out_valid=1
//   out_valid    out  FIFO non-empty
//   out_ready    in   head is consumed when out_valid && out_ready
//   count        out  FIFO occupancy, 0..DEPTH
//   frame_err    out  one-cycle pulse: stop bit sampled low
//   parity_err   out  one-cycle pulse: parity mismatch (parity build only)
//   overrun      out  sticky: a good byte arrived while the FIFO was full
//   overrun_clr  in   clears overrun; a new overrun on the same cycle wins
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH        = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Rx,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                     parity_err,
`endif
  output logic                     overrun,
  input  logic                     overrun_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  logic            r_rx_meta, r_rxs;
  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_clk_cnt;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            r_armed, r_push_pend, r_frame_err;
  logic            w_sample, w_bit_end, w_half_end, w_cnt_clr, w_stop_smp, w_par_bad;

  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr, r_rd, w_rd_nxt;
  logic [AW:0]     r_count, w_cnt_nxt;
  logic [7:0]      r_out_data, w_head_nxt;
  logic            r_out_valid, r_overrun;
  logic            w_full, w_pop, w_push;

  // Synchronizer: resets to the idle line level so reset never fakes a start.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= Rx;
      r_rxs     <= r_rx_meta;
    end
  end

  assign w_bit_end  = (r_clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign w_half_end = (r_clk_cnt == CW'(CLKS_PER_BIT / 2 - 1));
  assign w_stop_smp = (r_state == S_STOP) && w_bit_end;
  // START only waits half a bit so every later sample lands mid-bit.
  assign w_cnt_clr  = (r_state == S_IDLE) ||
                      ((r_state == S_START) ? w_half_end : w_bit_end);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sample    = 1'b0;
    case (r_state)
      // r_armed keeps a held-low break from being taken as a stream of starts.
      S_IDLE:  if (!r_rxs && r_armed) w_state_nxt = S_START;
      S_START: if (w_half_end) w_state_nxt = r_rxs ? S_IDLE : S_DATA;
      S_DATA: begin
        if (w_bit_end) begin
          w_sample = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
`else
          if (r_bit_cnt == 3'd7) w_state_nxt = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (w_bit_end) w_state_nxt = S_STOP;
`endif
      S_STOP:  if (w_bit_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
    end else begin
      if (w_cnt_clr) r_clk_cnt <= '0;
      else           r_clk_cnt <= r_clk_cnt + CW'(1);
      if (r_state == S_IDLE) r_bit_cnt <= '0;
      else if (w_sample)     r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  // Shift register stays put through PARITY/STOP and the push cycle, so it
  // doubles as the FIFO write data.
  always_ff @(posedge CLK) begin
    if (w_sample) r_shift <= {r_rxs, r_shift[7:1]};
  end

`ifdef UART_RX_PARITY_EN
  logic r_par, r_parity_err;
  always_ff @(posedge CLK) begin
    if ((r_state == S_PARITY) && w_bit_end) r_par <= r_rxs;
  end
  assign w_par_bad = r_par ^ (^r_shift);
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_parity_err <= 1'b0;
    else      r_parity_err <= w_stop_smp && w_par_bad;
  end
  assign parity_err = r_parity_err;
`else
  assign w_par_bad = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_push_pend <= 1'b0;
      r_frame_err <= 1'b0;
      r_armed     <= 1'b1;
    end else begin
      r_push_pend <= w_stop_smp && r_rxs && !w_par_bad;
      r_frame_err <= w_stop_smp && !r_rxs;
      if (w_stop_smp && !r_rxs) r_armed <= 1'b0;
      else if (r_rxs)           r_armed <= 1'b1;
    end
  end

  // A pop on the push cycle frees the slot even when full.
  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_pop     = r_out_valid && out_ready;
  assign w_push    = r_push_pend && (!w_full || w_pop);
  assign w_rd_nxt  = r_rd + AW'(w_pop);
  assign w_cnt_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
  // Bypass when the incoming byte becomes the head in the same cycle.
  assign w_head_nxt = (w_push && (w_rd_nxt == r_wr)) ? r_shift : r_mem[w_rd_nxt];

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr] <= r_shift;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wr        <= '0;
      r_rd        <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      r_rd        <= w_rd_nxt;
      r_count     <= w_cnt_nxt;
      r_out_valid <= (w_cnt_nxt != '0);
      if (w_cnt_nxt != '0) r_out_data <= w_head_nxt;
      if (r_push_pend && w_full && !w_pop) r_overrun <= 1'b1;
      else if (overrun_clr)                r_overrun <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign count     = r_count;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at CLKS_PER_BIT=8, DEPTH=4.
module tb_uart_rx_fifo;
  localparam int CPB   = 8;
  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       Rx  = 1'b1;
  logic       out_ready   = 1'b0;
  logic       overrun_clr = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic [2:0] count;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       par_flip = 1'b0;
  int         pe_cnt = 0;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int fe_cnt = 0;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Rx         (Rx),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .count      (count),
    .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
  );

  always #5 CLK = ~CLK;

  // Pulse counters: one increment per clock cycle the pulse is high.
  always @(posedge CLK) begin
    if (frame_err) fe_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pe_cnt++;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, req);
    end
  endtask

  // One frame at exact bit timing, starting on a falling clock edge. With
  // pop_on_push, out_ready is high for exactly the cycle in which the byte is
  // written (the cycle after the stop-bit sample).
  task automatic send(input logic [7:0] b, input logic stop_bit, input logic pop_on_push);
    Rx = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      Rx = b[i];
      repeat (CPB) @(negedge CLK);
    end
`ifdef UART_RX_PARITY_EN
    Rx = (^b) ^ par_flip;
    repeat (CPB) @(negedge CLK);
`endif
    Rx = stop_bit;
    repeat (CPB - 1) @(negedge CLK);
    if (pop_on_push) out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
  endtask

  task automatic pop_one;
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " out_valid"}, 32'(out_valid), 0);
    chk({tag, " out_data"},  32'(out_data),  0);
    chk({tag, " count"},     32'(count),     0);
    chk({tag, " frame_err"}, 32'(frame_err), 0);
    chk({tag, " overrun"},   32'(overrun),   0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] drain [4];
    drain = '{8'hFF, 8'h3C, 8'h81, 8'h77};

    repeat (3) @(negedge CLK);
    chk_reset_outputs("reset");
    RST = 1'b1;
    repeat (4) @(negedge CLK);

    // single byte, then pop
    send(8'hA5, 1'b1, 1'b0);
    chk("t1 count",  32'(count),     1);
    chk("t1 valid",  32'(out_valid), 1);
    chk("t1 data",   32'(out_data),  'hA5);
    pop_one();
    chk("t1 count after pop", 32'(count),     0);
    chk("t1 valid after pop", 32'(out_valid), 0);

    // fill to DEPTH, fifth byte overruns
    send(8'h00, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    send(8'h3C, 1'b1, 1'b0);
    send(8'h81, 1'b1, 1'b0);
    send(8'h55, 1'b1, 1'b0);
    chk("t2 count",   32'(count),    4);
    chk("t2 overrun", 32'(overrun),  1);
    chk("t2 head",    32'(out_data), 'h00);
    overrun_clr = 1'b1;
    @(negedge CLK);
    overrun_clr = 1'b0;
    chk("t2 overrun cleared", 32'(overrun), 0);

    // full FIFO, pop on the push cycle
    send(8'h77, 1'b1, 1'b1);
    chk("t3 count",   32'(count),   4);
    chk("t3 overrun", 32'(overrun), 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3 drain %0d", i), 32'(out_data), 32'(drain[i]));
      pop_one();
    end
    chk("t3 empty count", 32'(count),     0);
    chk("t3 empty valid", 32'(out_valid), 0);

    // short low glitch is rejected
    Rx = 1'b0;
    repeat (3) @(negedge CLK);
    Rx = 1'b1;
    repeat (30) @(negedge CLK);
    chk("t4 count",     32'(count),     0);
    chk("t4 valid",     32'(out_valid), 0);
    chk("t4 frame_err", fe_cnt,         0);

    // framing error, break, recovery
    send(8'h5A, 1'b0, 1'b0);
    chk("t5 frame_err pulse", fe_cnt,     1);
    chk("t5 count",           32'(count), 0);
    repeat (16) @(negedge CLK);
    Rx = 1'b1;
    repeat (16) @(negedge CLK);
    chk("t5 break no restart", fe_cnt, 1);
    send(8'h12, 1'b1, 1'b0);
    chk("t5 count after 0x12", 32'(count),    1);
    chk("t5 data 0x12",        32'(out_data), 'h12);
    pop_one();

`ifdef UART_RX_PARITY_EN
    par_flip = 1'b1;
    send(8'h07, 1'b1, 1'b0);
    par_flip = 1'b0;
    chk("par bad pulse",     pe_cnt,     1);
    chk("par bad count",     32'(count), 0);
    chk("par bad no fe",     fe_cnt,     1);
    repeat (8) @(negedge CLK);
    send(8'h07, 1'b1, 1'b0);
    chk("par good count",    32'(count),    1);
    chk("par good data",     32'(out_data), 'h07);
    chk("par good no pulse", pe_cnt,        1);
    pop_one();
`endif

    // reset mid-DATA with two bytes queued
    send(8'h11, 1'b1, 1'b0);
    send(8'h22, 1'b1, 1'b0);
    chk("t6 queued",    32'(count),    2);
    chk("t6 head 0x11", 32'(out_data), 'h11);
    Rx = 1'b0;
    repeat (CPB) @(negedge CLK);
    Rx = 1'b1;
    repeat (CPB) @(negedge CLK);
    Rx = 1'b1;
    repeat (CPB) @(negedge CLK);
    Rx = 1'b0;
    repeat (CPB / 2) @(negedge CLK);
    RST = 1'b0;
    Rx  = 1'b1;
    @(negedge CLK);
    chk_reset_outputs("t6 in reset");
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (16) @(negedge CLK);
    chk("t6 idle after reset", 32'(count), 0);
    send(8'h4D, 1'b1, 1'b0);
    chk("t6 count after 0x4D", 32'(count),    1);
    chk("t6 data 0x4D",        32'(out_data), 'h4D);
    chk("t6 valid",            32'(out_valid), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
